cnet_prog_ctrl: RTL and testbench
=================================

CNET_PROG_CTRL -- requirements
Module: cnet_prog_ctrl

Interface
REQ-001 Parameter PROG_B_CYCLES, default 10, minimum rp_prog_b low time in cclk periods.
REQ-002 Parameter INIT_TIMEOUT, default 1024, max cclk periods waiting for each rp_init_b edge.
REQ-003 Parameter DONE_TIMEOUT, default 256, max cclk periods from last byte to rp_done high.
REQ-004 clk  in  1  single block clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-clk pulse requesting a reprogram.
REQ-007 prog_words  in  20  bitstream length in 32-bit words, sampled on accepted start.
REQ-008 wr_data  in  32  bitstream word, byte 0 = bits[7:0], sent first.
REQ-009 wr_valid  in  1  wr_data valid.
REQ-010 wr_ready  out  1  block accepts word; transfer when wr_valid & wr_ready at clk edge.
REQ-011 busy  out  1  high in any state but IDLE/DONE/ERROR.
REQ-012 prog_ok  out  1  sticky: last reprogram completed with rp_done.
REQ-013 err  out  1  sticky: last reprogram failed.
REQ-014 err_code  out  2  1 init timeout, 2 CRC (init_b low during load), 3 done timeout.
REQ-015 rp_cclk  out  1  configuration clock, clk/2.
REQ-016 rp_prog_b  out  1  active-low program.
REQ-017 rp_init_b  in  1  CNET init, low = clearing or CRC error.
REQ-018 rp_cs_b  out  1  active-low SelectMAP chip select.
REQ-019 rp_rdwr_b  out  1  0 = write; always driven 0 (reads unsupported).
REQ-020 rp_data  out  8  SelectMAP byte.
REQ-021 rp_done  in  1  CNET configuration done.

Function
REQ-022 rp_cclk SHALL toggle every clk; a "tick" is the clk edge where rp_cclk goes 1->0; FSM and all rp_* outputs change only on ticks, so they are stable at rising rp_cclk.
REQ-023 States: IDLE, PROG_LOW, WAIT_INIT_LOW, WAIT_INIT_HIGH, LOAD, WAIT_DONE, DONE, ERROR.
REQ-024 start accepted in IDLE/DONE/ERROR only (ignored when busy); clears prog_ok/err/err_code, latches prog_words, enters PROG_LOW on next tick.
REQ-025 PROG_LOW: rp_prog_b=0 for exactly PROG_B_CYCLES ticks, then rp_prog_b=1 -> WAIT_INIT_LOW.
REQ-026 WAIT_INIT_LOW: rp_init_b=0 -> WAIT_INIT_HIGH; WAIT_INIT_HIGH: rp_init_b=1 -> LOAD; either wait exceeding INIT_TIMEOUT ticks -> ERROR code 1.
REQ-027 LOAD: one 32-bit holding register; wr_ready=1 only when register empty and words remaining>0 (never outside LOAD).
REQ-028 Each tick with register full: rp_cs_b=0, rp_data=byte[idx], idx 0..3; after idx 3 register empty; tick with register empty: rp_cs_b=1.
REQ-029 Remaining count decrements per accepted word; last byte of last word sent -> WAIT_DONE with rp_cs_b=1; prog_words=0 skips LOAD.
REQ-030 rp_init_b=0 sampled on any tick in LOAD or WAIT_DONE -> ERROR code 2 (priority over done/timeout).
REQ-031 WAIT_DONE: rp_done=1 -> DONE, prog_ok=1; DONE_TIMEOUT ticks elapsed -> ERROR code 3.
REQ-032 DONE/ERROR: rp_prog_b=1, rp_cs_b=1; words offered after completion are never accepted.

Reset
REQ-033 reset_n low: state IDLE, rp_cclk=0, rp_prog_b=1, rp_cs_b=1, rp_rdwr_b=0, rp_data=0, wr_ready=0, busy=0, prog_ok=0, err=0, err_code=0, counters and holding register cleared.
REQ-034 Reset mid-operation SHALL abandon the transfer with no rp_prog_b pulse; held word discarded.

Configuration
REQ-035 Macro CNET_PROG_BITREV_EN defined: rp_data[i] = byte[7-i] (SelectMAP D0 = MSB); undefined: rp_data = byte unchanged.

Verification
REQ-036 Normal: prog_words=2, words 0x04030201, 0x08070605, model pulses init_b, raises done -> 8 cs_b-low ticks bytes 01..08 (bit-reversed with macro), prog_ok=1, busy=0.
REQ-037 prog_b width: start -> rp_prog_b low exactly 10 cclk periods, wr_ready 0 throughout.
REQ-038 Init timeout: rp_init_b held 1 -> ERROR after 1024 ticks, err=1, err_code=1, rp_prog_b=1.
REQ-039 CRC: rp_init_b driven 0 after 3rd byte -> ERROR code 2, cs_b=1 next tick, wr_ready=0.
REQ-040 Stalls/excess: wr_valid gaps -> rp_cs_b=1 during gaps, byte order intact; 3rd word offered with prog_words=2 never accepted; start while busy ignored.
REQ-041 Reset in LOAD after 5 bytes -> all outputs at reset values asynchronously; fresh start completes normally.

Source files
------------

// File: rtl/cnet_prog_ctrl_if.sv
// Host-side request, status and bitstream word stream of the CNET SelectMAP programmer.
// The master drives requests and words; the slave answers with status and wr_ready.
interface cnet_prog_ctrl_if;
   logic        start;
   logic [19:0] prog_words;
   logic [31:0] wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic        busy;
   logic        prog_ok;
   logic        err;
   logic [1:0]  err_code;

   modport master (
      output start, prog_words, wr_data, wr_valid,
      input  wr_ready, busy, prog_ok, err, err_code
   );

   modport slave (
      input  start, prog_words, wr_data, wr_valid,
      output wr_ready, busy, prog_ok, err, err_code
   );
endinterface

// File: rtl/cnet_prog_ctrl.sv
// Purpose: pulses rp_prog_b, tracks rp_init_b, streams words as SelectMAP bytes, waits for rp_done.
// Latency: start takes effect on the next cclk tick; each held word goes out as 4 bytes on 4 ticks.
// Backpressure: one-word holding register; wr_ready only in LOAD while empty with words left.
// CNET_PROG_BITREV_EN defined: rp_data is bit-reversed (SelectMAP D0 = MSB).
module cnet_prog_ctrl #(
   parameter int PROG_B_CYCLES = 10,
   parameter int INIT_TIMEOUT  = 1024,
   parameter int DONE_TIMEOUT  = 256
) (
   input  logic             clk,
   input  logic             reset_n,
   cnet_prog_ctrl_if.slave  host,
   output logic             rp_cclk,
   output logic             rp_prog_b,
   input  logic             rp_init_b,
   output logic             rp_cs_b,
   output logic             rp_rdwr_b,
   output logic [7:0]       rp_data,
   input  logic             rp_done
);
   localparam int MAX_AB  = (PROG_B_CYCLES > INIT_TIMEOUT) ? PROG_B_CYCLES : INIT_TIMEOUT;
   localparam int CNT_MAX = (MAX_AB > DONE_TIMEOUT) ? MAX_AB : DONE_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(PROG_B_CYCLES - 1);
   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PROG_LOW, S_WAIT_INIT_LOW, S_WAIT_INIT_HIGH,
      S_LOAD, S_WAIT_DONE, S_DONE, S_ERROR
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [19:0]      remaining;
   logic [31:0]      hold;
   logic             hold_full;
   logic [1:0]       idx;
   logic             start_pend;
   logic             prog_ok_q;
   logic             err_q;
   logic [1:0]       err_code_q;
   logic             busy;
   logic             wr_ready;
   logic             accept;
   logic             tick;
   logic [1:0]       fail_code;
   logic [7:0]       cur_byte;
   logic [7:0]       out_byte;

   // rp_cclk is high just before the edge that drops it, so that edge is the tick
   assign tick      = rp_cclk;
   assign busy      = !(state inside {S_IDLE, S_DONE, S_ERROR});
   assign wr_ready  = (state == S_LOAD) && !hold_full && (remaining != '0);
   assign accept    = host.wr_valid && wr_ready;
   assign cur_byte  = hold[{idx, 3'b000} +: 8];
   assign rp_rdwr_b = 1'b0;

   assign host.wr_ready = wr_ready;
   assign host.busy     = busy;
   assign host.prog_ok  = prog_ok_q;
   assign host.err      = err_q;
   assign host.err_code = err_code_q;

`ifdef CNET_PROG_BITREV_EN
   always_comb begin
      out_byte = '0;
      for (int i = 0; i < 8; i++) out_byte[i] = cur_byte[7-i];
   end
`else
   assign out_byte = cur_byte;
`endif

   // init_b low while loading or waiting for done outranks both done and the timeout
   always_comb begin
      fail_code = 2'd0;
      if (tick) begin
         case (state)
            S_WAIT_INIT_LOW:  if (rp_init_b && cnt == INIT_LAST) fail_code = 2'd1;
            S_WAIT_INIT_HIGH: if (!rp_init_b && cnt == INIT_LAST) fail_code = 2'd1;
            S_LOAD:           if (!rp_init_b) fail_code = 2'd2;
            S_WAIT_DONE: begin
               if (!rp_init_b)                       fail_code = 2'd2;
               else if (!rp_done && cnt == DONE_LAST) fail_code = 2'd3;
            end
            default: fail_code = 2'd0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         rp_cclk    <= 1'b0;
         rp_prog_b  <= 1'b1;
         rp_cs_b    <= 1'b1;
         rp_data    <= '0;
         cnt        <= '0;
         remaining  <= '0;
         hold       <= '0;
         hold_full  <= 1'b0;
         idx        <= '0;
         start_pend <= 1'b0;
         prog_ok_q  <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= '0;
      end else begin
         rp_cclk <= ~rp_cclk;
         if (host.start && !busy) begin
            prog_ok_q  <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            remaining  <= host.prog_words;
            start_pend <= 1'b1;
         end
         if (accept) begin
            hold      <= host.wr_data;
            hold_full <= 1'b1;
            remaining <= remaining - 1'b1;
         end
         if (fail_code != 2'd0) begin
            state      <= S_ERROR;
            err_q      <= 1'b1;
            err_code_q <= fail_code;
            rp_cs_b    <= 1'b1;
            hold_full  <= 1'b0;
         end else if (tick) begin
            case (state)
               S_IDLE, S_DONE, S_ERROR: begin
                  if (start_pend) begin
                     start_pend <= 1'b0;
                     state      <= S_PROG_LOW;
                     rp_prog_b  <= 1'b0;
                     cnt        <= '0;
                     idx        <= '0;
                  end
               end
               S_PROG_LOW: begin
                  if (cnt == PROG_LAST) begin
                     rp_prog_b <= 1'b1;
                     cnt       <= '0;
                     state     <= S_WAIT_INIT_LOW;
                  end else cnt <= cnt + 1'b1;
               end
               S_WAIT_INIT_LOW: begin
                  if (!rp_init_b) begin
                     cnt   <= '0;
                     state <= S_WAIT_INIT_HIGH;
                  end else cnt <= cnt + 1'b1;
               end
               S_WAIT_INIT_HIGH: begin
                  if (rp_init_b) begin
                     cnt   <= '0;
                     state <= (remaining == '0) ? S_WAIT_DONE : S_LOAD;
                  end else cnt <= cnt + 1'b1;
               end
               S_LOAD: begin
                  if (hold_full) begin
                     rp_cs_b <= 1'b0;
                     rp_data <= out_byte;
                     idx     <= idx + 1'b1;
                     if (idx == 2'd3) begin
                        hold_full <= 1'b0;
                        if (remaining == '0) state <= S_WAIT_DONE;
                     end
                  end else rp_cs_b <= 1'b1;
               end
               S_WAIT_DONE: begin
                  rp_cs_b <= 1'b1;
                  if (rp_done) begin
                     state     <= S_DONE;
                     prog_ok_q <= 1'b1;
                  end else cnt <= cnt + 1'b1;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_cnet_prog_ctrl.sv
// Randomized bench for cnet_prog_ctrl: a CNET device model drives init_b/done and the
// expected SelectMAP byte stream is derived directly from the words offered.
module tb_cnet_prog_ctrl;
   localparam int PROG_B  = 10;
   localparam int INIT_TO = 1024;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rp_cclk, rp_prog_b, rp_cs_b, rp_rdwr_b;
   logic [7:0] rp_data;
   logic       rp_init_b, rp_done;

   cnet_prog_ctrl_if host_if ();

   cnet_prog_ctrl dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .host      (host_if),
      .rp_cclk   (rp_cclk),
      .rp_prog_b (rp_prog_b),
      .rp_init_b (rp_init_b),
      .rp_cs_b   (rp_cs_b),
      .rp_rdwr_b (rp_rdwr_b),
      .rp_data   (rp_data),
      .rp_done   (rp_done)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  got_q[$];
   logic [31:0] words[8];
   int          n_acc, n_offer, lo_cnt, rdy_bad;
   bit          feed_en;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int i);
      logic [31:0] w = words[i/4];
      logic [7:0]  b = w[(i%4)*8 +: 8];
      logic [7:0]  r;
`ifdef CNET_PROG_BITREV_EN
      for (int j = 0; j < 8; j++) r[j] = b[7-j];
`else
      r = b;
`endif
      return r;
   endfunction

   task automatic chk_reset(input string tag);
      chk(tag, {rp_cclk, rp_prog_b, rp_cs_b, rp_rdwr_b, rp_data, host_if.wr_ready,
                host_if.busy, host_if.prog_ok, host_if.err, host_if.err_code},
               {1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
   endtask

   task automatic chk_bytes(input int nw);
      for (int i = 0; i < got_q.size() && i < 4*nw; i++)
         chk($sformatf("byte%0d", i), got_q[i], exp_byte(i));
   endtask

   // Samples once per cclk period, at the negedge following the rising rp_cclk
   always @(negedge clk) begin
      if (rp_cclk) begin
         if (!rp_cs_b) got_q.push_back(rp_data);
         if (!rp_prog_b) begin
            lo_cnt++;
            if (host_if.wr_ready) rdy_bad++;
         end
      end
   end

   initial begin : feeder
      logic xfer;
      host_if.wr_valid = 1'b0;
      host_if.wr_data  = '0;
      forever begin
         @(negedge clk);
         xfer = host_if.wr_valid && host_if.wr_ready;
         @(posedge clk);
         #1;
         if (xfer) n_acc++;
         if (feed_en && n_acc < n_offer && $urandom_range(0, 3) != 0) begin
            host_if.wr_valid = 1'b1;
            host_if.wr_data  = words[n_acc];
         end else host_if.wr_valid = 1'b0;
      end
   end

   task automatic pulse_start(input int nw);
      @(posedge clk); #1;
      host_if.prog_words = 20'(nw);
      host_if.start      = 1'b1;
      @(posedge clk); #1;
      host_if.start      = 1'b0;
   endtask

   task automatic wait_prog_pulse();
      for (int k = 0; k < 100 && rp_prog_b; k++) @(negedge clk);
      for (int k = 0; k < 200 && !rp_prog_b; k++) @(negedge clk);
   endtask

   // mode 0 normal, 1 init_b low after 3rd byte, 2 reset after 5th byte, 3 done never rises
   task automatic do_run(input int nw, input int mode, input bit fixed);
      int target;
      bit bs_done = 1'b0;
      rp_done   = 1'b0;
      rp_init_b = 1'b1;
      feed_en   = 1'b0;
      for (int i = 0; i < 8; i++) words[i] = $urandom;
      if (fixed) begin
         words[0] = 32'h04030201;
         words[1] = 32'h08070605;
      end
      n_offer = nw + 1;
      @(posedge clk); #1;
      got_q.delete();
      n_acc = 0; lo_cnt = 0; rdy_bad = 0;
      pulse_start(nw);
      wait_prog_pulse();
      chk("prog_b_width", lo_cnt, PROG_B);
      chk("rdy_in_prog_low", rdy_bad, 0);
      repeat (2*$urandom_range(1, 8)) @(posedge clk);
      #1 rp_init_b = 1'b0;
      repeat (2*$urandom_range(1, 8)) @(posedge clk);
      #1 rp_init_b = 1'b1;
      feed_en = 1'b1;
      target = (mode == 1) ? 3 : (mode == 2) ? 5 : 4*nw;
      for (int k = 0; k < 4000; k++) begin
         if (got_q.size() >= target) break;
         @(posedge clk); #1;
         if (fixed && !bs_done && got_q.size() >= 2) begin
            host_if.prog_words = 20'd7;
            host_if.start      = 1'b1;
            @(posedge clk); #1;
            host_if.start      = 1'b0;
            bs_done            = 1'b1;
         end
      end
      chk("bytes_reached", got_q.size() >= target, 1'b1);
      case (mode)
         0: begin
            repeat (2*$urandom_range(0, 20)) @(posedge clk);
            #1 rp_done = 1'b1;
            for (int k = 0; k < 100 && !(host_if.prog_ok || host_if.err); k++) @(negedge clk);
            repeat (12) @(negedge clk);
            chk("prog_ok", host_if.prog_ok, 1'b1);
            chk("err_clear", host_if.err, 1'b0);
            chk("busy_after", host_if.busy, 1'b0);
            chk("cs_b_after", rp_cs_b, 1'b1);
            chk("words_accepted", n_acc, nw);
            chk("byte_count", got_q.size(), 4*nw);
            chk("no_second_pulse", lo_cnt, PROG_B);
            chk_bytes(nw);
         end
         1: begin
            rp_init_b = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("crc_err", host_if.err, 1'b1);
            chk("crc_code", host_if.err_code, 2'd2);
            chk("crc_cs_b", rp_cs_b, 1'b1);
            chk("crc_wr_ready", host_if.wr_ready, 1'b0);
            chk_bytes(nw);
         end
         2: begin
            #2 reset_n = 1'b0;
            #1 chk_reset("reset_mid_load");
            chk_bytes(nw);
            feed_en = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk) reset_n = 1'b1;
            repeat (10) @(negedge clk);
            chk("reset_no_pulse", lo_cnt, PROG_B);
         end
         default: begin
            for (int k = 0; k < 1000 && !host_if.err; k++) @(negedge clk);
            chk("done_to_err", host_if.err, 1'b1);
            chk("done_to_code", host_if.err_code, 2'd3);
            chk("done_to_ok", host_if.prog_ok, 1'b0);
         end
      endcase
      feed_en   = 1'b0;
      rp_init_b = 1'b1;
   endtask

   initial begin
      int n;
      reset_n            = 1'b0;
      host_if.start      = 1'b0;
      host_if.prog_words = '0;
      rp_init_b          = 1'b1;
      rp_done            = 1'b0;
      feed_en            = 1'b0;
      n_acc = 0; n_offer = 0; lo_cnt = 0; rdy_bad = 0;
      repeat (3) @(posedge clk);
      #1 chk_reset("reset_state");
      @(negedge clk) reset_n = 1'b1;

      do_run(2, 0, 1'b1);
      repeat (4) do_run($urandom_range(0, 6), 0, 1'b0);

      // init_b never drops: timeout counted in cclk periods after prog_b release
      rp_done = 1'b0;
      pulse_start(1);
      wait_prog_pulse();
      n = 0;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (host_if.err) break;
         if (rp_cclk) n++;
      end
      chk("init_to_ticks", n, INIT_TO);
      chk("init_to_code", host_if.err_code, 2'd1);
      chk("init_to_prog_b", rp_prog_b, 1'b1);
      chk("init_to_busy", host_if.busy, 1'b0);
      n_acc = 0; n_offer = 2; feed_en = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("err_no_accept", n_acc, 0);
      feed_en = 1'b0;

      do_run(3, 1, 1'b0);
      do_run(1, 3, 1'b0);
      do_run(3, 2, 1'b0);
      repeat (2) do_run($urandom_range(1, 6), 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
